// File: rtl/acc_serial_pkg.sv
// Shared definitions for the accumulator serial transmitter: FSM state encoding
// and the idle level of the serial line.
package acc_serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic TX_IDLE = 1'b1;

endpackage

// File: rtl/acc_serial_tx_baud_tick.sv
// Bit-period timer: modulo-CLK_DIV counter that emits a one-cycle tick on the
// last cycle of every serial bit while running.
module baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_terminal;

  assign w_terminal = (r_cnt == CW'(CLK_DIV - 1));
  assign o_tick     = i_run && w_terminal;

  // Clearing on load restarts the period so the start bit is a full CLK_DIV long.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= w_terminal ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/acc_serial_tx.sv
// UART-style serialiser for the accumulator OUT bus: start, LSB-first data,
// optional even parity (macro ACC_SERIAL_TX_PARITY_EN), stop.
module acc_serial_tx
  import acc_serial_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] IN,
  output logic             TX,
  output logic             BUSY,
  output logic             DONE
);

  localparam int BW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shifted;
  logic [BW-1:0]    r_bitCnt;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             w_txNext;
  logic             w_busyNext;
  logic             w_doneNext;
  logic             w_load;
  logic             w_shiftEn;
  logic             w_tick;
  logic             w_lastBit;
`ifdef ACC_SERIAL_TX_PARITY_EN
  logic             r_parity;
`endif

  baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clear (w_load),
    .i_run   (r_busy),
    .o_tick  (w_tick)
  );

  assign w_shifted = r_shift >> 1;
  assign w_lastBit = (r_bitCnt == BW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_tx    <= TX_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_tx    <= w_txNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
    end
  end

  // A load taken on the stop-bit edge starts the next frame with no idle gap.
  always_comb begin
    w_nextState = r_state;
    w_txNext    = r_tx;
    w_busyNext  = r_busy;
    w_doneNext  = 1'b0;
    w_load      = 1'b0;
    w_shiftEn   = 1'b0;
    case (r_state)
      IDLE: begin
        w_txNext   = TX_IDLE;
        w_busyNext = 1'b0;
        w_load     = EN;
      end
      START: begin
        if (w_tick) begin
          w_nextState = DATA;
          w_txNext    = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shiftEn = 1'b1;
          if (w_lastBit) begin
`ifdef ACC_SERIAL_TX_PARITY_EN
            w_nextState = PARITY;
            w_txNext    = r_parity;
`else
            w_nextState = STOP;
            w_txNext    = TX_IDLE;
`endif
          end else begin
            w_txNext = w_shifted[0];
          end
        end
      end
`ifdef ACC_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_nextState = STOP;
          w_txNext    = TX_IDLE;
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          w_nextState = IDLE;
          w_txNext    = TX_IDLE;
          w_busyNext  = 1'b0;
          w_doneNext  = 1'b1;
          w_load      = EN;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_txNext    = TX_IDLE;
        w_busyNext  = 1'b0;
      end
    endcase
    if (w_load) begin
      w_nextState = START;
      w_txNext    = 1'b0;
      w_busyNext  = 1'b1;
    end
  end

  // Parity is taken from the word at load time, not from the shifting register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
`ifdef ACC_SERIAL_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_load) begin
      r_shift  <= IN;
      r_bitCnt <= '0;
`ifdef ACC_SERIAL_TX_PARITY_EN
      r_parity <= ^IN;
`endif
    end else if (w_shiftEn) begin
      r_shift  <= w_shifted;
      r_bitCnt <= r_bitCnt + 1'b1;
    end
  end

  assign TX   = r_tx;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_acc_serial_tx.sv
// Self-checking bench for acc_serial_tx: directed frames plus random traffic
// compared cycle by cycle against a waveform-queue reference model.
module tb_acc_serial_tx;

  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 4;

  logic             CLK;
  logic             RST;
  logic             EN;
  logic [WIDTH-1:0] IN;
  logic             TX;
  logic             BUSY;
  logic             DONE;

  int nChecks;
  int nFails;
  int doneCount;
  int lastDoneCycle;
  int doneGap;
  int cycle;

  logic expTxQ[$];
  logic expTx;
  logic expBusy;
  logic expDone;

  acc_serial_tx #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .IN   (IN),
    .TX   (TX),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected line waveform of one whole frame, one entry per clock cycle.
  task automatic pushFrame(input logic [WIDTH-1:0] w);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) bits.push_back(w[i]);
`ifdef ACC_SERIAL_TX_PARITY_EN
    bits.push_back(^w);
`endif
    bits.push_back(1'b1);
    foreach (bits[b])
      for (int c = 0; c < CLK_DIV; c++) expTxQ.push_back(bits[b]);
  endtask

  task automatic checkOutput(input string tag);
    nChecks++;
    assert (TX === expTx) else begin
      nFails++;
      $error("[TB] FAIL %s tx cycle %0d: got %b expected %b", tag, cycle, TX, expTx);
    end
    nChecks++;
    assert (BUSY === expBusy) else begin
      nFails++;
      $error("[TB] FAIL %s busy cycle %0d: got %b expected %b", tag, cycle, BUSY, expBusy);
    end
    nChecks++;
    assert (DONE === expDone) else begin
      nFails++;
      $error("[TB] FAIL %s done cycle %0d: got %b expected %b", tag, cycle, DONE, expDone);
    end
  endtask

  // One rising edge with the given inputs; model updated, then outputs checked.
  task automatic applyStimulus(input logic en, input logic rst,
                               input logic [WIDTH-1:0] din, input string tag);
    logic wasBusy;
    EN  = en;
    RST = rst;
    IN  = din;
    @(posedge CLK);
    cycle++;
    if (rst) begin
      expTxQ.delete();
      expDone = 1'b0;
    end else begin
      wasBusy = (expTxQ.size() > 0);
      if (wasBusy) void'(expTxQ.pop_front());
      expDone = wasBusy && (expTxQ.size() == 0);
      if (expTxQ.size() == 0 && en) pushFrame(din);
    end
    expBusy = (expTxQ.size() > 0);
    expTx   = expBusy ? expTxQ[0] : 1'b1;
    #1;
    if (DONE === 1'b1) begin
      doneGap       = cycle - lastDoneCycle;
      lastDoneCycle = cycle;
      doneCount++;
    end
    checkOutput(tag);
  endtask

  initial begin
    nChecks = 0; nFails = 0; doneCount = 0; lastDoneCycle = 0; doneGap = 0; cycle = 0;
    expTx = 1'b1; expBusy = 1'b0; expDone = 1'b0;
    EN = 1'b0; RST = 1'b1; IN = '0;

    applyStimulus(1'b0, 1'b1, 8'h00, "reset");
    applyStimulus(1'b0, 1'b1, 8'h00, "reset");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, "idle");

    // 0x55 frame followed by a few idle cycles.
    doneCount = 0;
    applyStimulus(1'b1, 1'b0, 8'h55, "f55");
    for (int i = 1; i < 45; i++) applyStimulus(1'b0, 1'b0, 8'h00, "f55");
    nChecks++;
    assert (doneCount === 1) else begin
      nFails++;
      $error("[TB] FAIL f55_donecount: got %0d expected 1", doneCount);
    end

    // 0xA3 with EN re-asserted mid-frame carrying 0xFF.
    doneCount = 0;
    applyStimulus(1'b1, 1'b0, 8'hA3, "fA3");
    for (int k = 1; k < 46; k++)
      applyStimulus((k >= 8 && k < 11), 1'b0, (k >= 8) ? 8'hFF : 8'hA3, "fA3");
    nChecks++;
    assert (doneCount === 1) else begin
      nFails++;
      $error("[TB] FAIL fA3_donecount: got %0d expected 1", doneCount);
    end

    // Back-to-back frames: EN held high through the DONE edge.
    doneCount = 0;
    applyStimulus(1'b1, 1'b0, 8'h0F, "b2b");
    for (int k = 1; k < (WIDTH + 2) * CLK_DIV + 1; k++) applyStimulus(1'b1, 1'b0, 8'hF0, "b2b");
    for (int k = 0; k < (WIDTH + 3) * CLK_DIV + 4; k++) applyStimulus(1'b0, 1'b0, 8'h00, "b2b");
    nChecks++;
    assert (doneCount === 2) else begin
      nFails++;
      $error("[TB] FAIL b2b_donecount: got %0d expected 2", doneCount);
    end
`ifndef ACC_SERIAL_TX_PARITY_EN
    nChecks++;
    assert (doneGap === 40) else begin
      nFails++;
      $error("[TB] FAIL b2b_gap: got %0d expected 40", doneGap);
    end
`endif

    // Reset mid-frame aborts without DONE, then a clean 0x01 frame.
    doneCount = 0;
    applyStimulus(1'b1, 1'b0, 8'hFF, "abort");
    for (int k = 1; k < 15; k++) applyStimulus(1'b0, 1'b0, 8'h00, "abort");
    applyStimulus(1'b0, 1'b1, 8'h00, "abort");
    for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b0, 8'h00, "abort");
    nChecks++;
    assert (doneCount === 0) else begin
      nFails++;
      $error("[TB] FAIL abort_nodone: got %0d expected 0", doneCount);
    end
    applyStimulus(1'b1, 1'b0, 8'h01, "f01");
    for (int k = 1; k < 48; k++) applyStimulus(1'b0, 1'b0, 8'h00, "f01");

`ifdef ACC_SERIAL_TX_PARITY_EN
    applyStimulus(1'b1, 1'b0, 8'h07, "par07");
    for (int k = 1; k < 48; k++) applyStimulus(1'b0, 1'b0, 8'h00, "par07");
    applyStimulus(1'b1, 1'b0, 8'h03, "par03");
    for (int k = 1; k < 48; k++) applyStimulus(1'b0, 1'b0, 8'h00, "par03");
`endif

    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++)
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0),
                    WIDTH'($urandom), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
